// File: rtl/fsgnj_x_unit_pkg.sv
// Shared FP sign-injection definitions: op encodings and width constants.
package fsgnj_x_unit_pkg;

  localparam int unsigned FLEN_DEFAULT = 32;
  localparam int unsigned SIGN_IDX     = FLEN_DEFAULT - 1;
  localparam int unsigned OP_W         = 2;

  typedef enum logic [OP_W-1:0] {
    SGNJ      = 2'b00,
    SGNJN     = 2'b01,
    SGNJX     = 2'b10,
    SGNJ_PASS = 2'b11
  } sgnj_op_e;

endpackage

// File: rtl/fsgnj_core.sv
// Combinational sign injection: magnitude from rs1, sign chosen by op_type.
module fsgnj_core
  import fsgnj_x_unit_pkg::*;
#(
  parameter int unsigned FLEN = FLEN_DEFAULT
) (
  input  logic [FLEN-1:0] rs1,
  input  logic [FLEN-1:0] rs2,
  input  logic [1:0]      op_type,
  output logic [FLEN-1:0] rd
);

  localparam int unsigned SB = FLEN - 1;

  logic w_s1;
  logic w_s2;
  logic w_sign;
  logic w_unused_rs2_mag;

  assign w_s1 = rs1[SB];
  assign w_s2 = rs2[SB];

  // Only the sign of rs2 matters; its magnitude is intentionally dropped.
  assign w_unused_rs2_mag = ^rs2[SB-1:0];

  // Select the result sign; pass-through keeps rs1's own sign.
  always_comb begin
    w_sign = w_s1;
    case (sgnj_op_e'(op_type))
      SGNJ:      w_sign = w_s2;
      SGNJN:     w_sign = ~w_s2;
      SGNJX:     w_sign = w_s1 ^ w_s2;
      SGNJ_PASS: w_sign = w_s1;
    endcase
  end

  assign rd = {w_sign, rs1[SB-1:0]};

endmodule

// File: rtl/fsgnj_x_unit.sv
// One-stage registered sign-injection unit with valid/ready handshake.
module fsgnj_x_unit
  import fsgnj_x_unit_pkg::*;
#(
  parameter int unsigned FLEN = FLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] rs1,
  input  logic [FLEN-1:0] rs2,
  input  logic [1:0]      op_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] rd
);

  logic [FLEN-1:0] w_rd;
  logic            w_accept;
  logic            r_out_valid;
  logic [FLEN-1:0] r_rd;

  fsgnj_core #(.FLEN(FLEN)) u_core (
    .rs1     (rs1),
    .rs2     (rs2),
    .op_type (op_type),
    .rd      (w_rd)
  );

  // Ready whenever the output slot is empty or is being drained this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Output register: fill on accept (even while draining), clear on plain drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rd        <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rd        <= w_rd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign rd        = r_rd;

endmodule

// File: tb/tb_fsgnj_x_unit.sv
// Self-checking bench for fsgnj_x_unit: directed vectors, handshake corners, random scoreboard.
module tb_fsgnj_x_unit;

  localparam int unsigned FLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [FLEN-1:0] rs1;
  logic [FLEN-1:0] rs2;
  logic [1:0]      op_type;
  logic            out_valid;
  logic            out_ready;
  logic [FLEN-1:0] rd;

  int checks;
  int errors;

  fsgnj_x_unit #(.FLEN(FLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .op_type   (op_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] q[$];

  // Reference: magnitude of rs1 plus a sign computed arithmetically from the op rules.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    int unsigned mag;
    int unsigned s1;
    int unsigned s2;
    int unsigned s;
    mag = a % 32'h8000_0000;
    s1  = a / 32'h8000_0000;
    s2  = b / 32'h8000_0000;
    case (op)
      2'd0:    s = s2;
      2'd1:    s = 1 - s2;
      2'd2:    s = (s1 + s2) % 2;
      default: s = s1;
    endcase
    return 32'(s * 32'h8000_0000 + mag);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic ordy);
    in_valid  = v;
    rs1       = a;
    rs2       = b;
    op_type   = op;
    out_ready = ordy;
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] exp4[4];
    logic [31:0] e;
    logic        acc;
    int          accepted;
    int          delivered;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'h3F800000, 32'hBF800000, 2'b00, 32'hBF800000};
    vecs[1] = '{32'h3F800000, 32'hBF800000, 2'b01, 32'h3F800000};
    vecs[2] = '{32'h3F800000, 32'hBF800000, 2'b10, 32'hBF800000};
    vecs[3] = '{32'h3F800000, 32'hBF800000, 2'b11, 32'h3F800000};
    vecs[4] = '{32'hFF800900, 32'hF2802110, 2'b00, 32'hFF800900};
    vecs[5] = '{32'hFF800900, 32'hF2802110, 2'b01, 32'h7F800900};
    vecs[6] = '{32'hFF800900, 32'hF2802110, 2'b10, 32'h7F800900};
    vecs[7] = '{32'hFF800900, 32'hF2802110, 2'b11, 32'hFF800900};

    // Reset state
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_rd", rd, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Directed sign-injection vectors at full throughput
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
      tick();
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_rd_hold", rd, 32'hFF800900);

    // Back-pressure: result held stable while inputs churn
    drive(1'b1, 32'h40490FDB, 32'h80000000, 2'b00, 1'b1);
    tick();
    held = 32'hC0490FDB;
    chk("bp_first", rd, held);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
      #1;
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("bp_rd%0d", i), rd, held);
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Back-to-back: four results on four consecutive cycles
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h00001000 + 32'(i), (i % 2 == 1) ? 32'h80000000 : 32'h0, 2'b00, 1'b1);
      exp4[i] = 32'h00001000 + 32'(i) + ((i % 2 == 1) ? 32'h80000000 : 32'h0);
      tick();
      chk($sformatf("b2b_rd%0d", i), rd, exp4[i]);
      chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    tick();

    // Asynchronous reset with a held result
    drive(1'b1, 32'h12345678, 32'h80000000, 2'b00, 1'b0);
    tick();
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_rd", rd, 32'h0);
    chk("rst_async_in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    drive(1'b1, 32'h7FC00001, 32'h80000000, 2'b10, 1'b1);
    tick();
    chk("rst_after_rd", rd, 32'hFFC00001);
    chk("rst_after_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    tick();

    // Random traffic against the scoreboard queue
    q.delete();
    accepted  = 0;
    delivered = 0;
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      #1;
      if (in_ready !== ((q.size() == 0) || out_ready))
        chk("rnd_in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
      acc = in_valid && ((q.size() == 0) || out_ready);
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        chk("rnd_rd", rd, e);
        delivered++;
      end
      if (acc) begin
        q.push_back(ref_model(rs1, rs2, op_type));
        accepted++;
      end
      tick();
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rnd_final_rd", rd, e);
      delivered++;
    end
    tick();
    chk("rnd_final_valid", 32'(out_valid), 32'd0);
    chk("rnd_count", 32'(delivered), 32'(accepted));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
